ap_cam_array: RTL and testbench

//  Parametrised associative-processor CAM array: DATA_DEPTH words of DATA_WIDTH bits with
//  row/column write and read, masked key compare into a tag register with accumulation,
//  tag-qualified parallel write, and a first-match priority encoder. Driven by the AP

---
 rtl/ap_cam_array.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_ap_cam_array.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_cam_array.sv
// ap_cam_array: associative-processor CAM array.
// DATA_DEPTH words of DATA_WIDTH bits with row/column write and read, masked key
// compare into an accumulating tag register, tag-qualified parallel write and a
// lowest-index priority encoder on the tag.
//
// Command/response handshake: a command transfers on a rising edge where
// cmd_valid && cmd_ready; a response transfers on a rising edge where
// rsp_valid && rsp_ready. Once raised, rsp_valid and the response data stay
// stable until that transfer. cmd_ready is high only in IDLE, so commands are
// never queued.
module ap_cam_array #(
    parameter int DATA_WIDTH     = 8,
    parameter int DATA_DEPTH     = 16,
    parameter int ADDR_WIDTH_CAM = 8
) (
    input  logic                             clk,
    input  logic                             rstIn,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [2:0]                       cmd_op,
    input  logic [ADDR_WIDTH_CAM-1:0]        cmd_addr,
    input  logic [DATA_WIDTH-1:0]            cmd_row_data,
    input  logic [DATA_DEPTH-1:0]            cmd_col_data,
    input  logic [DATA_WIDTH-1:0]            cmd_key,
    input  logic [DATA_WIDTH-1:0]            cmd_mask,
    input  logic [1:0]                       cmd_acc,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_row_data,
    output logic [DATA_DEPTH-1:0]            rsp_col_data,
    output logic                             rsp_err,
    output logic [DATA_DEPTH-1:0]            tag,
    output logic                             tag_any,
    output logic [ADDR_WIDTH_CAM-1:0]        tag_first,
    output logic [DATA_WIDTH*DATA_DEPTH-1:0] Q,
    output logic [DATA_DEPTH-1:0]            Q_S,
    output logic [1:0]                       dbg_state
);

    // Index widths used to address rows and columns once the range check passed
    localparam int ROW_IW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam int COL_IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [ADDR_WIDTH_CAM-1:0] ROW_LIM = ADDR_WIDTH_CAM'(DATA_DEPTH);
    localparam logic [ADDR_WIDTH_CAM-1:0] COL_LIM = ADDR_WIDTH_CAM'(DATA_WIDTH);

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_WR_ROW    = 3'd1;
    localparam logic [2:0] OP_WR_COL    = 3'd2;
    localparam logic [2:0] OP_RD_ROW    = 3'd3;
    localparam logic [2:0] OP_RD_COL    = 3'd4;
    localparam logic [2:0] OP_COMPARE   = 3'd5;
    localparam logic [2:0] OP_WR_TAGGED = 3'd6;
    localparam logic [2:0] OP_TAG_INIT  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                       state_q, state_d;

    // Storage and tag
    logic [DATA_WIDTH-1:0]        mem_q [DATA_DEPTH];
    logic [DATA_WIDTH-1:0]        mem_d [DATA_DEPTH];
    logic [DATA_DEPTH-1:0]        tag_q, tag_d;

    // Command fields captured at accept
    logic [2:0]                   op_q, op_d;
    logic [ADDR_WIDTH_CAM-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]        row_data_q, row_data_d;
    logic [DATA_DEPTH-1:0]        col_data_q, col_data_d;
    logic [DATA_WIDTH-1:0]        key_q, key_d;
    logic [DATA_WIDTH-1:0]        mask_q, mask_d;
    logic [1:0]                   acc_q, acc_d;

    // Response registers
    logic                         rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]        rsp_row_q, rsp_row_d;
    logic [DATA_DEPTH-1:0]        rsp_col_q, rsp_col_d;
    logic                         rsp_err_q, rsp_err_d;

    // Derived from the registered command
    logic                         row_ok;
    logic                         col_ok;
    logic [ROW_IW-1:0]            row_idx;
    logic [COL_IW-1:0]            col_idx;
    logic [DATA_DEPTH-1:0]        match;
    logic                         accept;

    // Address decode of the registered command
    always_comb begin
        row_ok  = (addr_q < ROW_LIM);
        col_ok  = (addr_q < COL_LIM);
        row_idx = addr_q[ROW_IW-1:0];
        col_idx = addr_q[COL_IW-1:0];
    end

    // Masked key compare: a row matches when every participating column equals the key
    always_comb begin
        match = '0;
        for (int i = 0; i < DATA_DEPTH; i++) begin
            match[i] = &(~mask_q | ~(mem_q[i] ^ key_q));
        end
    end

    assign accept = cmd_valid && cmd_ready;

    // Next-state logic for the FSM, the array, the tag and the response
    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        tag_d       = tag_q;
        op_d        = op_q;
        addr_d      = addr_q;
        row_data_d  = row_data_q;
        col_data_d  = col_data_q;
        key_d       = key_q;
        mask_d      = mask_q;
        acc_d       = acc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_row_d   = rsp_row_q;
        rsp_col_d   = rsp_col_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d       = cmd_op;
                    addr_d     = cmd_addr;
                    row_data_d = cmd_row_data;
                    col_data_d = cmd_col_data;
                    key_d      = cmd_key;
                    mask_d     = cmd_mask;
                    acc_d      = cmd_acc;
                    state_d    = S_EXEC;
                end
            end

            S_EXEC: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_row_d   = '0;
                rsp_col_d   = '0;
                rsp_err_d   = 1'b0;
                case (op_q)
                    OP_WR_ROW: begin
                        if (row_ok) mem_d[row_idx] = row_data_q;
                        else        rsp_err_d = 1'b1;
                    end
                    OP_WR_COL: begin
                        if (col_ok) begin
                            for (int i = 0; i < DATA_DEPTH; i++) begin
                                mem_d[i][col_idx] = col_data_q[i];
                            end
                        end else begin
                            rsp_err_d = 1'b1;
                        end
                    end
                    OP_RD_ROW: begin
                        if (row_ok) rsp_row_d = mem_q[row_idx];
                        else        rsp_err_d = 1'b1;
                    end
                    OP_RD_COL: begin
                        if (col_ok) begin
                            for (int i = 0; i < DATA_DEPTH; i++) begin
                                rsp_col_d[i] = mem_q[i][col_idx];
                            end
                        end else begin
                            rsp_err_d = 1'b1;
                        end
                    end
                    OP_COMPARE: begin
                        case (acc_q)
                            2'b01:   tag_d = tag_q & match;
                            2'b10:   tag_d = tag_q | match;
                            default: tag_d = match;
                        endcase
                    end
                    OP_WR_TAGGED: begin
                        for (int i = 0; i < DATA_DEPTH; i++) begin
                            if (tag_q[i]) mem_d[i] = (mem_q[i] & ~mask_q) | (key_q & mask_q);
                        end
                    end
                    OP_TAG_INIT: begin
                        tag_d = {DATA_DEPTH{key_q[0]}};
                    end
                    OP_NOP: begin
                        rsp_err_d = 1'b0;
                    end
                    default: begin
                        rsp_err_d = 1'b0;
                    end
                endcase
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_row_d   = '0;
                    rsp_col_d   = '0;
                    rsp_err_d   = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops any command in flight and clears the array
    always_ff @(posedge clk or posedge rstIn) begin
        if (rstIn) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < DATA_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            tag_q       <= '0;
            op_q        <= OP_NOP;
            addr_q      <= '0;
            row_data_q  <= '0;
            col_data_q  <= '0;
            key_q       <= '0;
            mask_q      <= '0;
            acc_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_row_q   <= '0;
            rsp_col_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            for (int i = 0; i < DATA_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            tag_q       <= tag_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            row_data_q  <= row_data_d;
            col_data_q  <= col_data_d;
            key_q       <= key_d;
            mask_q      <= mask_d;
            acc_q       <= acc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_row_q   <= rsp_row_d;
            rsp_col_q   <= rsp_col_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Lowest set tag bit wins; scanning downward lets the lowest index overwrite
    always_comb begin
        tag_first = '0;
        for (int i = DATA_DEPTH - 1; i >= 0; i--) begin
            if (tag_q[i]) tag_first = ADDR_WIDTH_CAM'(i);
        end
    end

    // Flat array view and MSB column
    always_comb begin
        Q   = '0;
        Q_S = '0;
        for (int i = 0; i < DATA_DEPTH; i++) begin
            Q[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
            Q_S[i]                        = mem_q[i][DATA_WIDTH-1];
        end
    end

    assign cmd_ready    = (state_q == S_IDLE) && !rstIn;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_row_data = rsp_row_q;
    assign rsp_col_data = rsp_col_q;
    assign rsp_err      = rsp_err_q;
    assign tag          = tag_q;
    assign tag_any      = |tag_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ap_cam_array.sv
// Bench for ap_cam_array: directed scenarios plus random command stream,
// checked against an array/tag reference model kept in the bench.
module tb_ap_cam_array;

  localparam int W = 8;
  localparam int D = 16;
  localparam int A = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstIn;
  always #5 clk = ~clk;

  logic           cmd_valid;
  logic           cmd_ready;
  logic [2:0]     cmd_op;
  logic [A-1:0]   cmd_addr;
  logic [W-1:0]   cmd_row_data;
  logic [D-1:0]   cmd_col_data;
  logic [W-1:0]   cmd_key;
  logic [W-1:0]   cmd_mask;
  logic [1:0]     cmd_acc;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_row_data;
  logic [D-1:0]   rsp_col_data;
  logic           rsp_err;
  logic [D-1:0]   tag;
  logic           tag_any;
  logic [A-1:0]   tag_first;
  logic [W*D-1:0] Q;
  logic [D-1:0]   Q_S;
  logic [1:0]     dbg_state;

  ap_cam_array #(.DATA_WIDTH(W), .DATA_DEPTH(D), .ADDR_WIDTH_CAM(A)) dut (
    .clk(clk), .rstIn(rstIn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_row_data(cmd_row_data), .cmd_col_data(cmd_col_data), .cmd_key(cmd_key),
    .cmd_mask(cmd_mask), .cmd_acc(cmd_acc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_row_data(rsp_row_data),
    .rsp_col_data(rsp_col_data), .rsp_err(rsp_err),
    .tag(tag), .tag_any(tag_any), .tag_first(tag_first), .Q(Q), .Q_S(Q_S),
    .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  logic [W-1:0] m_mem [D];
  logic [D-1:0] m_tag;

  int n_vec = 0;
  int n_err = 0;

  // scoreboard of expected responses, consumed one per command
  logic [W+D:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [W*D-1:0] m_flat();
    logic [W*D-1:0] f;
    for (int i = 0; i < D; i++) f[i*W +: W] = m_mem[i];
    return f;
  endfunction

  function automatic logic [D-1:0] m_msb();
    logic [D-1:0] s;
    for (int i = 0; i < D; i++) s[i] = m_mem[i][W-1];
    return s;
  endfunction

  function automatic logic [A-1:0] m_first();
    for (int i = 0; i < D; i++) if (m_tag[i]) return A'(i);
    return '0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_tag = '0;
  endtask

  // apply one command to the model and push its expected response
  task automatic m_apply(input logic [2:0] op, input logic [A-1:0] addr, input logic [W-1:0] row,
                         input logic [D-1:0] col, input logic [W-1:0] key,
                         input logic [W-1:0] mask, input logic [1:0] acc);
    logic [W-1:0] e_row;
    logic [D-1:0] e_col;
    logic         e_err;
    logic [D-1:0] m;
    e_row = '0; e_col = '0; e_err = 1'b0;
    case (op)
      3'd1: if (addr < D) m_mem[addr] = row; else e_err = 1'b1;
      3'd2: if (addr < W) begin
              for (int i = 0; i < D; i++) m_mem[i][addr] = col[i];
            end else e_err = 1'b1;
      3'd3: if (addr < D) e_row = m_mem[addr]; else e_err = 1'b1;
      3'd4: if (addr < W) begin
              for (int i = 0; i < D; i++) e_col[i] = m_mem[i][addr];
            end else e_err = 1'b1;
      3'd5: begin
              for (int i = 0; i < D; i++) m[i] = (((m_mem[i] ^ key) & mask) == 0);
              if (acc == 2'b01)      m_tag = m_tag & m;
              else if (acc == 2'b10) m_tag = m_tag | m;
              else                   m_tag = m;
            end
      3'd6: for (int i = 0; i < D; i++)
              if (m_tag[i]) m_mem[i] = (m_mem[i] & ~mask) | (key & mask);
      3'd7: m_tag = key[0] ? '1 : '0;
      default: ;
    endcase
    exp_q.push_back({e_err, e_col, e_row});
  endtask

  task automatic check_view(input string where);
    chk({where, "_Q"}, Q, m_flat());
    chk({where, "_Q_S"}, Q_S, m_msb());
    chk({where, "_tag"}, tag, m_tag);
    chk({where, "_tag_any"}, tag_any, |m_tag);
    chk({where, "_tag_first"}, tag_first, m_first());
  endtask

  // ---------------- driver ----------------
  task automatic do_cmd(input logic [2:0] op, input logic [A-1:0] addr, input logic [W-1:0] row,
                        input logic [D-1:0] col, input logic [W-1:0] key,
                        input logic [W-1:0] mask, input logic [1:0] acc, input int hold);
    int cnt;
    logic [W+D:0] e;
    logic [W-1:0] held_row;
    logic [D-1:0] held_col;
    logic         held_err;
    @(negedge clk);
    cmd_op = op; cmd_addr = addr; cmd_row_data = row; cmd_col_data = col;
    cmd_key = key; cmd_mask = mask; cmd_acc = acc; cmd_valid = 1'b1;
    cnt = 0;
    while (!cmd_ready && cnt < 20) begin @(negedge clk); cnt++; end
    if (!cmd_ready) begin chk("cmd_ready_timeout", 0, 1); cmd_valid = 1'b0; return; end
    m_apply(op, addr, row, col, key, mask, acc);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("exec_no_rsp", rsp_valid, 1'b0);
    cnt = 0;
    while (!rsp_valid && cnt < 20) begin @(negedge clk); cnt++; end
    e = exp_q.pop_front();
    if (!rsp_valid) begin chk("rsp_timeout", 0, 1); return; end
    chk("rsp_row", rsp_row_data, e[W-1:0]);
    chk("rsp_col", rsp_col_data, e[W+D-1:W]);
    chk("rsp_err", rsp_err, e[W+D]);
    held_row = rsp_row_data; held_col = rsp_col_data; held_err = rsp_err;
    // backpressure: response must hold, new commands must be refused
    for (int k = 0; k < hold; k++) begin
      cmd_op = 3'd1; cmd_addr = '0; cmd_row_data = 8'hFF; cmd_valid = 1'b1;
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_stable", {rsp_err, rsp_col_data, rsp_row_data}, {held_err, held_col, held_row});
      chk("bp_cmd_ready", cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_dropped", rsp_valid, 1'b0);
    check_view("post");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]   op;
    logic [A-1:0] addr;
    logic [W-1:0] key;
    logic [W-1:0] mask;
    rstIn = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_addr = '0; cmd_row_data = '0; cmd_col_data = '0;
    cmd_key = '0; cmd_mask = '0; cmd_acc = '0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    check_view("rst");
    rstIn = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1'b1);

    // row write then row/column reads
    do_cmd(3'd1, 8'd3, 8'hA5, '0, '0, '0, 2'b00, 0);
    do_cmd(3'd3, 8'd3, '0, '0, '0, '0, 2'b00, 0);
    do_cmd(3'd4, 8'd0, '0, '0, '0, '0, 2'b00, 0);
    do_cmd(3'd3, 8'd3, '0, '0, '0, '0, 2'b00, 5);

    // column write, out-of-range row read
    do_cmd(3'd2, 8'd7, '0, 16'h8001, '0, '0, 2'b00, 0);
    chk("colw_qs0", Q_S[0], 1'b1);
    chk("colw_qs15", Q_S[15], 1'b1);
    do_cmd(3'd3, 8'd16, '0, '0, '0, '0, 2'b00, 0);
    do_cmd(3'd1, 8'd16, 8'h77, '0, '0, '0, 2'b00, 0);
    do_cmd(3'd4, 8'd8, '0, '0, '0, '0, 2'b00, 0);

    // compare / accumulate / tagged write
    for (int i = 0; i < D; i++) do_cmd(3'd1, A'(i), (i == 2 || i == 5) ? 8'h3C : 8'h00, '0, '0, '0, 2'b00, 0);
    do_cmd(3'd5, '0, '0, '0, 8'h3C, 8'hFF, 2'b00, 0);
    chk("cmp_tag", tag, 16'h0024);
    chk("cmp_first", tag_first, 8'd2);
    chk("cmp_any", tag_any, 1'b1);
    do_cmd(3'd5, '0, '0, '0, 8'h00, 8'h01, 2'b01, 0);
    chk("cmp_and_tag", tag, 16'h0024);
    do_cmd(3'd6, '0, '0, '0, 8'h01, 8'h0F, 2'b00, 0);
    chk("wrt_row2", Q[2*W +: W], 8'h31);
    chk("wrt_row5", Q[5*W +: W], 8'h31);
    chk("wrt_row4", Q[4*W +: W], 8'h00);
    do_cmd(3'd5, '0, '0, '0, 8'h00, 8'hFF, 2'b10, 0);
    chk("cmp_or_tag", tag, 16'hFFFF);
    do_cmd(3'd7, '0, '0, '0, 8'h00, '0, 2'b00, 0);
    chk("init0_any", tag_any, 1'b0);
    chk("init0_first", tag_first, 8'd0);
    do_cmd(3'd5, '0, '0, '0, 8'h5A, 8'h00, 2'b00, 0);
    chk("mask0_tag", tag, 16'hFFFF);
    do_cmd(3'd0, 8'd3, 8'hFF, '1, '1, '1, 2'b11, 2);

    // reset during EXEC drops the command
    do_cmd(3'd1, 8'd9, 8'h5A, '0, '0, '0, 2'b00, 0);
    do_cmd(3'd7, '0, '0, '0, 8'h01, '0, 2'b00, 0);
    @(negedge clk);
    cmd_op = 3'd1; cmd_addr = 8'd1; cmd_row_data = 8'h77; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rstIn = 1'b1;
    #1;
    m_reset();
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
    check_view("mid_rst");
    @(negedge clk);
    rstIn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", rsp_valid, 1'b0);
    end
    check_view("post_rst");

    // random command stream
    for (int n = 0; n < 200; n++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd2 || op == 3'd4) addr = A'($urandom_range(0, 10));
      else                          addr = A'($urandom_range(0, 19));
      if ($urandom_range(0, 1) == 1) key = m_mem[$urandom_range(0, D - 1)];
      else                           key = W'($urandom);
      mask = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      do_cmd(op, addr, W'($urandom), D'($urandom), key, mask, 2'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
